// File: rtl/ddr_pkg.sv
// ddr_pkg: shared types and constants for the DDR arbiter slice.
//   state_t        : arbiter FSM states
//   BA_W/ROW_W/COL_W: word-address field widths {bank, row, col}
//   T_RFC / T_RP   : controller timing constants (clocks)
package ddr_pkg;

  localparam int unsigned BA_W   = 2;
  localparam int unsigned ROW_W  = 13;
  localparam int unsigned COL_W  = 9;
  localparam int unsigned ADDR_W = BA_W + ROW_W + COL_W;
  localparam int unsigned DATA_W = 16;
  localparam int unsigned OWED_W = 4;

  localparam int unsigned T_RFC = 13;
  localparam int unsigned T_RP  = 3;

  typedef enum logic [2:0] {
    IDLE,
    READ,
    WRITE,
    REFRESH,
    GAP
  } state_t;

  typedef struct packed {
    logic [BA_W-1:0]  ba;
    logic [ROW_W-1:0] row;
    logic [COL_W-1:0] col;
  } ddr_addr_t;

endpackage

// File: rtl/ddr_refresh_timer.sv
// ddr_refresh_timer: free-running refresh interval counter plus a saturating
// count of refreshes owed to the DRAM.
//   clk, rst      : clock, async active-high reset
//   credit_take   : arbiter is issuing one refresh this edge
//   refresh_owed  : refreshes currently owed (saturates at MAX_PENDING)
module ddr_refresh_timer
  import ddr_pkg::*;
#(
  parameter int unsigned REFRESH_INTERVAL = 1000,
  parameter int unsigned MAX_PENDING      = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              credit_take,
  output logic [OWED_W-1:0] refresh_owed
);

  localparam int unsigned CNT_W = (REFRESH_INTERVAL > 1) ? $clog2(REFRESH_INTERVAL) : 1;

  logic [CNT_W-1:0] interval_cnt;
  logic             credit_c;

  assign credit_c = (interval_cnt == CNT_W'(REFRESH_INTERVAL - 1));

  // Interval counter wraps on each credit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      interval_cnt <= '0;
    end else if (credit_c) begin
      interval_cnt <= '0;
    end else begin
      interval_cnt <= interval_cnt + CNT_W'(1);
    end
  end

  // Owed count: a credit and an issue on the same edge cancel out.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      refresh_owed <= '0;
    end else begin
      case ({credit_c, credit_take})
        2'b10: if (refresh_owed != OWED_W'(MAX_PENDING)) refresh_owed <= refresh_owed + OWED_W'(1);
        2'b01: if (refresh_owed != '0) refresh_owed <= refresh_owed - OWED_W'(1);
        default: refresh_owed <= refresh_owed;
      endcase
    end
  end

endmodule

// File: rtl/ddr_arbiter.sv
// ddr_arbiter: sole master of the DDR controller. Arbitrates a read client and
// a write client, injects periodic auto-refresh, and turns the controller's
// level-request / one-cycle-ack protocol into per-client req/ack handshakes.
// Optional: DDR_ARB_ROUND_ROBIN_EN alternates read/write priority when both
// clients request; otherwise reads always win over writes.
//   clk, rst                       : clock, async active-high reset
//   rd_req/rd_addr/rd_ack/rd_data  : read client
//   wr_req/wr_addr/wr_data/wr_ack  : write client
//   ddr_read/ddr_write/ddr_refresh : controller requests
//   ddr_addr/ddr_wdata             : controller address / write data
//   ddr_read_ack/ddr_write_ack/ddr_rdata : controller responses
//   refresh_owed                   : pending refresh count (debug)
module ddr_arbiter
  import ddr_pkg::*;
#(
  parameter int unsigned REFRESH_INTERVAL = 1000,
  parameter int unsigned REFRESH_GAP      = 15,
  parameter int unsigned MAX_PENDING      = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_ack,
  output logic [DATA_W-1:0] rd_data,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ack,
  output logic              ddr_read,
  output logic              ddr_write,
  output logic              ddr_refresh,
  output logic [ADDR_W-1:0] ddr_addr,
  output logic [DATA_W-1:0] ddr_wdata,
  input  logic              ddr_read_ack,
  input  logic              ddr_write_ack,
  input  logic [DATA_W-1:0] ddr_rdata,
  output logic [OWED_W-1:0] refresh_owed
);

  localparam int unsigned GAP_W = (REFRESH_GAP > 1) ? $clog2(REFRESH_GAP) : 1;

  if (REFRESH_GAP < T_RFC + 2) begin : g_gap_check
    $error("REFRESH_GAP shorter than tRFC+2");
  end

  state_t            state, state_nxt;
  logic [GAP_W-1:0]  gap_cnt, gap_cnt_nxt;
  logic              rd_ack_nxt, wr_ack_nxt;
  logic              ddr_read_nxt, ddr_write_nxt, ddr_refresh_nxt;
  logic [ADDR_W-1:0] ddr_addr_nxt;
  logic [DATA_W-1:0] ddr_wdata_nxt, rd_data_nxt;
  logic              grant_rd_c, grant_wr_c, gap_done_c, credit_take_c, owed_c;
`ifdef DDR_ARB_ROUND_ROBIN_EN
  logic              prefer_wr, prefer_wr_nxt;
`endif

  assign owed_c        = (refresh_owed != '0);
  assign gap_done_c    = (gap_cnt == GAP_W'(REFRESH_GAP - 1));
  assign credit_take_c = (state_nxt == REFRESH);

  // Client selection when no refresh is owed.
  always_comb begin
`ifdef DDR_ARB_ROUND_ROBIN_EN
    grant_rd_c = rd_req && (!wr_req || !prefer_wr);
`else
    grant_rd_c = rd_req;
`endif
    grant_wr_c = wr_req && !grant_rd_c;
  end

  ddr_refresh_timer #(
    .REFRESH_INTERVAL(REFRESH_INTERVAL),
    .MAX_PENDING     (MAX_PENDING)
  ) u_refresh_timer (
    .clk         (clk),
    .rst         (rst),
    .credit_take (credit_take_c),
    .refresh_owed(refresh_owed)
  );

  // State and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      gap_cnt     <= '0;
      rd_ack      <= 1'b0;
      wr_ack      <= 1'b0;
      rd_data     <= '0;
      ddr_read    <= 1'b0;
      ddr_write   <= 1'b0;
      ddr_refresh <= 1'b0;
      ddr_addr    <= '0;
      ddr_wdata   <= '0;
`ifdef DDR_ARB_ROUND_ROBIN_EN
      prefer_wr   <= 1'b0;
`endif
    end else begin
      state       <= state_nxt;
      gap_cnt     <= gap_cnt_nxt;
      rd_ack      <= rd_ack_nxt;
      wr_ack      <= wr_ack_nxt;
      rd_data     <= rd_data_nxt;
      ddr_read    <= ddr_read_nxt;
      ddr_write   <= ddr_write_nxt;
      ddr_refresh <= ddr_refresh_nxt;
      ddr_addr    <= ddr_addr_nxt;
      ddr_wdata   <= ddr_wdata_nxt;
`ifdef DDR_ARB_ROUND_ROBIN_EN
      prefer_wr   <= prefer_wr_nxt;
`endif
    end
  end

  // Next state: refresh first, and owed refreshes chain straight out of GAP.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (owed_c)          state_nxt = REFRESH;
        else if (grant_rd_c) state_nxt = READ;
        else if (grant_wr_c) state_nxt = WRITE;
      end
      READ:    if (ddr_read_ack)  state_nxt = IDLE;
      WRITE:   if (ddr_write_ack) state_nxt = IDLE;
      REFRESH: state_nxt = GAP;
      GAP:     if (gap_done_c) state_nxt = owed_c ? REFRESH : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Next output values: address/data latched at grant, acks are single pulses.
  always_comb begin
    rd_ack_nxt      = 1'b0;
    wr_ack_nxt      = 1'b0;
    ddr_refresh_nxt = 1'b0;
    rd_data_nxt     = rd_data;
    ddr_read_nxt    = ddr_read;
    ddr_write_nxt   = ddr_write;
    ddr_addr_nxt    = ddr_addr;
    ddr_wdata_nxt   = ddr_wdata;
    gap_cnt_nxt     = gap_cnt;
`ifdef DDR_ARB_ROUND_ROBIN_EN
    prefer_wr_nxt   = prefer_wr;
`endif
    case (state)
      IDLE: begin
        case (state_nxt)
          REFRESH: ddr_refresh_nxt = 1'b1;
          READ: begin
            ddr_read_nxt = 1'b1;
            ddr_addr_nxt = rd_addr;
`ifdef DDR_ARB_ROUND_ROBIN_EN
            prefer_wr_nxt = 1'b1;
`endif
          end
          WRITE: begin
            ddr_write_nxt = 1'b1;
            ddr_addr_nxt  = wr_addr;
            ddr_wdata_nxt = wr_data;
`ifdef DDR_ARB_ROUND_ROBIN_EN
            prefer_wr_nxt = 1'b0;
`endif
          end
          default: ;
        endcase
      end
      READ: begin
        if (ddr_read_ack) begin
          ddr_read_nxt = 1'b0;
          rd_data_nxt  = ddr_rdata;
          rd_ack_nxt   = 1'b1;
        end
      end
      WRITE: begin
        if (ddr_write_ack) begin
          ddr_write_nxt = 1'b0;
          wr_ack_nxt    = 1'b1;
        end
      end
      REFRESH: gap_cnt_nxt = '0;
      GAP: begin
        if (gap_done_c) begin
          if (state_nxt == REFRESH) ddr_refresh_nxt = 1'b1;
        end else begin
          gap_cnt_nxt = gap_cnt + GAP_W'(1);
        end
      end
      default: ;
    endcase
  end

endmodule

// File: doc/ddr_arbiter.md
Name: ddr_arbiter

Overview:
- Sits directly upstream of the DDR SDRAM controller, as its only master.
- Arbitrates between a read client (the VGA line fetch, which must not underrun) and a write client (the drawing engine).
- Generates the periodic auto-refresh request.
- Converts the controller's level-request / one-cycle-acknowledge protocol into per-client req/ack handshakes, and holds address and data stable for the whole transaction.

Parameters:
- REFRESH_INTERVAL, 1000: clocks between refresh credits (7.5 us at 133 MHz; below tREFI 7.8 us).
- REFRESH_GAP, 15: clocks after a refresh pulse before any new controller request (≥ tRFC+2).
- MAX_PENDING, 8: saturation limit of owed refreshes (JEDEC postpone limit).

Ports:
- clk  in  1  controller clock; block uses rising edge, controller samples on falling edge.
- rst  in  1  reset.
- rd_req  in  1  read client request, level; held until rd_ack.
- rd_addr  in  24  read word address {bank[1:0], row[12:0], col[8:0]}.
- rd_ack  out  1  one-cycle pulse; rd_data valid in the same cycle.
- rd_data  out  16  captured read word.
- wr_req  in  1  write client request, level; held until wr_ack.
- wr_addr  in  24  write word address.
- wr_data  in  16  write word; sampled at grant.
- wr_ack  out  1  one-cycle pulse on write completion.
- ddr_read  out  1  to controller read.
- ddr_write  out  1  to controller write.
- ddr_refresh  out  1  to controller refresh.
- ddr_addr  out  24  drives both controller readAddress and writeAddress.
- ddr_wdata  out  16  to controller writeData.
- ddr_read_ack  in  1  from controller readAcknowledge.
- ddr_write_ack  in  1  from controller writeAcknowledge.
- ddr_rdata  in  16  from controller readData.
- refresh_owed  out  4  pending refresh count (debug).

Behaviour:
- Reset: rst, asynchronous, active-high. All outputs 0; state IDLE; interval counter 0; pending 0.
- Refresh timer:
  - Free-running counter. On reaching REFRESH_INTERVAL-1 it wraps to 0 and pending increments, saturating at MAX_PENDING.
  - A simultaneous credit and issue leaves pending unchanged.
- FSM states: IDLE, READ, WRITE, REFRESH, GAP.
- IDLE, priority order:
  - pending≠0 → REFRESH.
  - else rd_req → READ.
  - else wr_req → WRITE.
  - ddr_addr and ddr_wdata are registered at grant and are stable until ack.
- READ: ddr_read=1 from the grant edge, held until ddr_read_ack is sampled high. On that edge: ddr_read←0, rd_data←ddr_rdata, rd_ack←1, → IDLE.
- WRITE: same sequence using ddr_write, ddr_write_ack and wr_ack.
- Never assert ddr_read and ddr_write simultaneously. The controller resolves read first, so overlap would corrupt a write.
- REFRESH: ddr_refresh=1 for exactly one clock, pending decrements, → GAP.
- GAP: counts REFRESH_GAP clocks, then → IDLE. Remaining pending refreshes are issued back-to-back through GAP.
- Latency: request seen in IDLE at edge N → ddr_* asserted after edge N+1. Client ack is asserted one edge after the controller ack.
- A client request dropped before its ack is a protocol violation. The transaction completes; its ack is still pulsed.
- Refresh pulses issued during controller initialisation are ignored by the controller. This is accepted; init performs its own refreshes.
- Reset mid-transaction: returns immediately to the reset state. The controller is reset from the same rst.

Optional Feature:
- Macro: DDR_ARB_ROUND_ROBIN_EN.
- Defined: a last-granted bit alternates read/write priority when both are requested. Refresh stays highest priority.
- Undefined: fixed read-over-write priority; writes may starve while rd_req is held.

Decomposition:
- Shared package ddr_pkg holds:
  - the state enum;
  - the address field widths (BA 2, ROW 13, COL 9);
  - the controller timing constants tRFC=13 and tRP=3.
- Sub-module ddr_refresh_timer contains the interval counter and pending saturating counter. Interface: credit_take in, refresh_owed out.

Test Plan:
- rd_req=1, rd_addr=24'h40_1234, controller model acks after 9 clocks with ddr_rdata=16'hBEEF → ddr_read high 9 clocks, ddr_addr=24'h401234, rd_ack one pulse with rd_data=16'hBEEF.
- rd_req and wr_req asserted together, fixed priority → read granted first; ddr_write rises only after rd_ack; ddr_read and ddr_write are never both high.
- Idle for 1000 clocks → one-clock ddr_refresh pulse; a request arriving in GAP is not forwarded for 15 clocks.
- Continuous reads over 10×REFRESH_INTERVAL with refresh blocked → refresh_owed saturates at 8, then 8 refreshes issue, spaced 16 clocks apart.
- With DDR_ARB_ROUND_ROBIN_EN and both requests held → grants alternate R, W, R, W.
- rst asserted mid-WRITE → all outputs 0 asynchronously; after release, refresh_owed=0 and the first refresh is issued after 1000 clocks.
